// File: rtl/eco_pkg.sv
// Shared definitions for the ultrasonic echo generator and the level-meter side.
package eco_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TRIG  = 3'd1,
        ST_BURST = 3'd2,
        ST_ECHO  = 3'd3,
        ST_REARM = 3'd4
    } eco_state_e;

    // Default timing at a 50 MHz clock.
    localparam int UNIT_TICKS_DEF     = 2900;     // 58 us per cm
    localparam int TRIG_MIN_TICKS_DEF = 500;      // 10 us minimum trigger
    localparam int BURST_TICKS_DEF    = 10000;    // 8 x 40 kHz burst, 200 us
    localparam int TIMEOUT_TICKS_DEF  = 1900000;  // 38 ms no-target echo
    localparam int MAX_DIST_DEF       = 400;      // largest valid distance

    localparam int DIST_W = 11;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/eco_sync.sv
// Two-flop synchronizer for the asynchronous trigger input.
module eco_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Both flops clear on reset so a trigger held across reset is seen as a fresh rise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/eco_gen.sv
// Ultrasonic sensor emulator: validates a trigger pulse, waits out the burst,
// then returns an echo whose width encodes the latched target distance.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for synchronized trigger high
// TRIG     | measuring trigger width (saturating counter)
// BURST    | trigger accepted, distance latched, echo held low
// ECHO     | echo high for dist x UNIT_TICKS (or TIMEOUT_TICKS)
// REARM    | echo done while trigger still high; wait for trigger low
module eco_gen
    import eco_pkg::*;
#(
    parameter int UNIT_TICKS     = UNIT_TICKS_DEF,
    parameter int TRIG_MIN_TICKS = TRIG_MIN_TICKS_DEF,
    parameter int BURST_TICKS    = BURST_TICKS_DEF,
    parameter int TIMEOUT_TICKS  = TIMEOUT_TICKS_DEF,
    parameter int MAX_DIST       = MAX_DIST_DEF
) (
    input  logic              Clo,
    input  logic              Clr,
    input  logic              Trig,
    input  logic [DIST_W-1:0] Dist,
    output logic              Eco,
    output logic              Busy
);

    localparam int TICK_MAX = max_int(max_int(TIMEOUT_TICKS - 1, UNIT_TICKS - 1), BURST_TICKS);
    localparam int TICK_W   = cnt_width(TICK_MAX);
    localparam int WCNT_W   = cnt_width(TRIG_MIN_TICKS);

    localparam logic [TICK_W-1:0] UNIT_LD    = TICK_W'(UNIT_TICKS - 1);
    localparam logic [TICK_W-1:0] TIMEOUT_LD = TICK_W'(TIMEOUT_TICKS - 1);
    // The cycle in which the synchronized fall is detected is the first burst
    // cycle, so BURST itself lasts BURST_TICKS-1 cycles and the echo rises
    // exactly BURST_TICKS cycles after the synchronized trigger fall.
    localparam logic [TICK_W-1:0] BURST_LD   = TICK_W'(BURST_TICKS - 2);

    localparam logic [WCNT_W-1:0] WCNT_MIN = WCNT_W'(TRIG_MIN_TICKS);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);
    localparam logic [DIST_W-1:0] DIST_MAX = DIST_W'(MAX_DIST);
    localparam logic [DIST_W-1:0] DIST_ONE = DIST_W'(1);

    logic trig_s;

    eco_state_e        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q,  wcnt_d;
    logic [TICK_W-1:0] tick_q,  tick_d;
    logic [DIST_W-1:0] dcnt_q,  dcnt_d;
    logic [DIST_W-1:0] dist_q,  dist_d;
    logic              eco_q,   eco_d;
    logic              busy_q,  busy_d;
    logic              no_target;

    eco_sync u_sync (
        .clk_i (Clo),
        .rst_i (Clr),
        .d_i   (Trig),
        .q_o   (trig_s)
    );

    // Out-of-range distances report "no target" via the fixed timeout width.
    assign no_target = (dist_q == '0) || (dist_q > DIST_MAX);

    // Next-state, counter and output decode.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        tick_d  = tick_q;
        dcnt_d  = dcnt_q;
        dist_d  = dist_q;

        unique case (state_q)
            ST_IDLE: begin
                if (trig_s) begin
                    state_d = ST_TRIG;
                    // Count restarts here; this first high cycle is included.
                    wcnt_d  = WCNT_ONE;
                end
            end

            ST_TRIG: begin
                if (trig_s) begin
                    if (wcnt_q < WCNT_MIN) begin
                        wcnt_d = wcnt_q + WCNT_ONE;
                    end
                end else begin
                    wcnt_d = '0;
                    if (wcnt_q >= WCNT_MIN) begin
                        state_d = ST_BURST;
                        dist_d  = Dist;
                        tick_d  = BURST_LD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_BURST: begin
                if (tick_q == '0) begin
                    state_d = ST_ECHO;
                    if (no_target) begin
                        tick_d = TIMEOUT_LD;
                        dcnt_d = DIST_ONE;
                    end else begin
                        tick_d = UNIT_LD;
                        dcnt_d = dist_q;
                    end
                end else begin
                    tick_d = tick_q - 1'b1;
                end
            end

            ST_ECHO: begin
                if (tick_q == '0) begin
                    if (dcnt_q == DIST_ONE) begin
                        dcnt_d  = '0;
                        state_d = trig_s ? ST_REARM : ST_IDLE;
                    end else begin
                        dcnt_d = dcnt_q - DIST_ONE;
                        tick_d = UNIT_LD;
                    end
                end else begin
                    tick_d = tick_q - 1'b1;
                end
            end

            ST_REARM: begin
                if (!trig_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                wcnt_d  = '0;
                tick_d  = '0;
                dcnt_d  = '0;
            end
        endcase

        // Outputs follow the next state so they can be registered without lag.
        eco_d  = (state_d == ST_ECHO);
        busy_d = (state_d == ST_BURST) || (state_d == ST_ECHO) || (state_d == ST_REARM);
    end

    // State, counters, latched distance and registered outputs.
    always_ff @(posedge Clo) begin
        if (Clr) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            tick_q  <= '0;
            dcnt_q  <= '0;
            dist_q  <= '0;
            eco_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tick_q  <= tick_d;
            dcnt_q  <= dcnt_d;
            dist_q  <= dist_d;
            eco_q   <= eco_d;
            busy_q  <= busy_d;
        end
    end

    assign Eco  = eco_q;
    assign Busy = busy_q;

endmodule

// File: tb/tb_eco_gen.sv
// Directed bench for eco_gen with an echo scoreboard (expected rise cycle and width).
module tb_eco_gen;
    import eco_pkg::*;

    localparam int UNIT  = 10;
    localparam int TMIN  = 5;
    localparam int BURST = 20;
    localparam int TOUT  = 100;
    localparam int MAXD  = 400;
    // Trig driven low at a negedge reaches the FSM two edges later through the
    // synchronizer; the echo then rises BURST cycles after that synchronized fall.
    localparam int RISE_LAT = BURST + 2;

    logic        Clo = 1'b0;
    logic        Clr;
    logic        Trig;
    logic [10:0] Dist;
    logic        Eco;
    logic        Busy;

    eco_gen #(
        .UNIT_TICKS     (UNIT),
        .TRIG_MIN_TICKS (TMIN),
        .BURST_TICKS    (BURST),
        .TIMEOUT_TICKS  (TOUT),
        .MAX_DIST       (MAXD)
    ) dut (
        .Clo  (Clo),
        .Clr  (Clr),
        .Trig (Trig),
        .Dist (Dist),
        .Eco  (Eco),
        .Busy (Busy)
    );

    always #5 Clo = ~Clo;

    int cyc = 0;
    always @(posedge Clo) cyc <= cyc + 1;

    typedef struct {
        int rise;
        int width;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    // Echo monitor: pop on rise, compare rise cycle; compare width on fall.
    exp_t cur;
    int   rise_cyc = 0;
    logic eco_prev = 1'b0;
    always @(negedge Clo) begin
        if (Eco === 1'b1 && eco_prev !== 1'b1) begin
            if (sb.size() > 0) begin
                cur = sb.pop_front();
            end else begin
                cur.rise  = -1;
                cur.width = -1;
            end
            rise_cyc = cyc;
            check("echo_rise_cycle", cyc, cur.rise);
        end
        if (Eco === 1'b1) check("busy_during_echo", Busy, 1);
        if (Eco !== 1'b1 && eco_prev === 1'b1) check("echo_width", cyc - rise_cyc, cur.width);
        eco_prev = Eco;
    end

    // Pulse Trig for hi cycles; queue the expected echo when exp_w > 0.
    task automatic send_trig(input int hi, input int d, input int exp_w);
        exp_t e;
        Dist = 11'(d);
        Trig = 1'b1;
        repeat (hi) @(negedge Clo);
        Trig = 1'b0;
        if (exp_w > 0) begin
            e.rise  = cyc + RISE_LAT;
            e.width = exp_w;
            sb.push_back(e);
        end
        repeat (5) @(negedge Clo);
        check("busy_after_accept", Busy, (exp_w > 0) ? 1 : 0);
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n = 0;
        while ((sb.size() != 0 || Eco !== 1'b0) && n < max_cyc) begin
            @(negedge Clo);
            n++;
        end
        check(tag, sb.size(), 0);
        @(negedge Clo);
    endtask

    task automatic wait_eco(input string tag, input int max_cyc);
        int n = 0;
        while (Eco !== 1'b1 && n < max_cyc) begin
            @(negedge Clo);
            n++;
        end
        check(tag, Eco, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        Clr  = 1'b1;
        Trig = 1'b0;
        Dist = '0;
        repeat (3) @(negedge Clo);
        check("rst_eco", Eco, 0);
        check("rst_busy", Busy, 0);
        check("rst_state", dut.state_q, ST_IDLE);
        check("rst_dist", dut.dist_q, 0);
        Clr = 1'b0;
        repeat (3) @(negedge Clo);

        // Nominal: Dist=7 -> 70-cycle echo
        send_trig(8, 7, 7 * UNIT);
        wait_done("drain_d7", 200);
        check("busy_low_d7", Busy, 0);
        check("idle_d7", dut.state_q, ST_IDLE);

        // Short trigger: rejected
        send_trig(3, 7, 0);
        repeat (40) @(negedge Clo);
        check("short_eco", Eco, 0);
        check("short_busy", Busy, 0);
        check("short_state", dut.state_q, ST_IDLE);

        // No-target distances: 0 and MAX+1
        send_trig(8, 0, TOUT);
        wait_done("drain_d0", 300);
        send_trig(8, MAXD + 1, TOUT);
        wait_done("drain_d401", 300);
        check("busy_low_d401", Busy, 0);

        // Dist change and extra triggers during echo are ignored
        send_trig(8, 5, 5 * UNIT);
        wait_eco("eco_seen_d5", 100);
        Dist = 11'd300;
        Trig = 1'b1;
        repeat (6) @(negedge Clo);
        Trig = 1'b0;
        repeat (4) @(negedge Clo);
        Trig = 1'b1;
        repeat (6) @(negedge Clo);
        check("latched_dist", dut.dist_q, 5);
        Trig = 1'b0;
        wait_done("drain_d5", 200);
        repeat (40) @(negedge Clo);
        check("idle_after_extra", dut.state_q, ST_IDLE);

        // Long held trigger: single echo only after release
        send_trig(300, 2, 2 * UNIT);
        wait_done("drain_held", 200);
        repeat (40) @(negedge Clo);
        check("held_busy", Busy, 0);

        // Trigger high at echo end -> REARM, no new echo until low then high
        send_trig(8, 2, 2 * UNIT);
        wait_eco("eco_seen_rearm", 100);
        Trig = 1'b1;
        wait_done("drain_rearm", 100);
        check("rearm_state", dut.state_q, ST_REARM);
        check("rearm_busy", Busy, 1);
        repeat (20) @(negedge Clo);
        Trig = 1'b0;
        repeat (5) @(negedge Clo);
        check("rearm_exit_state", dut.state_q, ST_IDLE);
        check("rearm_exit_busy", Busy, 0);
        repeat (40) @(negedge Clo);

        // Clr at echo cycle 30 of Dist=10 aborts after 30 cycles high
        send_trig(8, 10, 30);
        wait_eco("eco_seen_clr", 100);
        repeat (29) @(negedge Clo);
        Clr = 1'b1;
        @(negedge Clo);
        Clr = 1'b0;
        check("clr_eco", Eco, 0);
        check("clr_busy", Busy, 0);
        check("clr_state", dut.state_q, ST_IDLE);
        check("clr_dist", dut.dist_q, 0);
        repeat (150) @(negedge Clo);
        send_trig(8, 10, 10 * UNIT);
        wait_done("drain_after_clr", 300);

        // Trigger already high across Clr release is a fresh trigger
        Clr  = 1'b1;
        Trig = 1'b1;
        Dist = 11'd3;
        repeat (3) @(negedge Clo);
        check("clr_hold_state", dut.state_q, ST_IDLE);
        Clr = 1'b0;
        repeat (3) @(negedge Clo);
        check("trig_after_release", dut.state_q, ST_TRIG);
        repeat (5) @(negedge Clo);
        Trig = 1'b0;
        e.rise  = cyc + RISE_LAT;
        e.width = 3 * UNIT;
        sb.push_back(e);
        wait_done("drain_release", 200);
        check("final_busy", Busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
